// File: rtl/sha256_kw_sched_pkg.sv
// Shared SHA-256 definitions for the K+W round-word scheduler: state
// encoding, schedule length and the small-sigma message expansion functions.
package sha256_kw_sched_pkg;

  localparam int ROUNDS = 64;
  localparam int WORDS  = 16;

  typedef logic [31:0] word_t;
  typedef logic [5:0]  round_t;

  localparam round_t LAST_ROUND = round_t'(ROUNDS - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  function automatic word_t sig0(input word_t x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
  endfunction

  function automatic word_t sig1(input word_t x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
  endfunction

endpackage

// File: rtl/sha256_kw_sched_if.sv
// Host-side bundle of the scheduler: start/block load, K table lookup and the
// valid/ready round-word stream. master = scheduler, slave = surrounding logic.
interface sha256_kw_sched_if;
  import sha256_kw_sched_pkg::*;

  logic         start;
  logic [511:0] block;
  round_t       k_addr;
  word_t        k_data;
  logic         kw_valid;
  logic         kw_ready;
  word_t        kw_data;
  round_t       kw_round;
  logic         busy;
  logic         done;

  modport master (
    input  start, block, k_data, kw_ready,
    output k_addr, kw_valid, kw_data, kw_round, busy, done
  );

  modport slave (
    output start, block, k_data, kw_ready,
    input  k_addr, kw_valid, kw_data, kw_round, busy, done
  );

endinterface

// File: rtl/sha256_w_window.sv
// 16-word sliding message window; each shift appends the next expanded word,
// so w[0] always holds W_t for the current round.
module sha256_w_window
  import sha256_kw_sched_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block,
  output word_t        w0
);

  word_t w [WORDS];
  word_t w_new;

  // Expansion is applied on every shift, including the first 16 rounds.
  assign w_new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WORDS; i++) w[i] <= '0;
    end else if (load) begin
      for (int i = 0; i < WORDS; i++) w[i] <= block[511 - 32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < WORDS - 1; i++) w[i] <= w[i + 1];
      w[WORDS - 1] <= w_new;
    end
  end

  assign w0 = w[0];

endmodule

// File: rtl/sha256_kw_sched.sv
// SHA-256 round-word scheduler: streams (K_t + W_t) for t = 0..63 over a
// valid/ready handshake, reading K from an external combinational table.
//
// state   | meaning
// --------+--------------------------------------------------------------
// IDLE    | waiting for start; outputs parked at zero, no valid word
// RUN     | presenting round t; advances on each kw_valid && kw_ready
// DONE    | one-cycle done pulse after round 63 is accepted
module sha256_kw_sched
  import sha256_kw_sched_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  sha256_kw_sched_if.master  bus
);

  logic [1:0] state;
  logic [1:0] state_nxt;
  round_t     t;
  word_t      w0;

  logic in_idle;
  logic in_run;
  logic in_done;
  logic load;
  logic xfer;
  logic last;

  assign in_idle = (state == ST_IDLE);
  assign in_run  = (state == ST_RUN);
  assign in_done = (state == ST_DONE);
  assign load    = in_idle && bus.start;
  assign xfer    = in_run && bus.kw_ready;
  assign last    = (t == LAST_ROUND);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.start)   state_nxt = ST_RUN;
      ST_RUN:  if (xfer && last) state_nxt = ST_DONE;
      ST_DONE:                  state_nxt = ST_IDLE;
      default:                  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      t     <= '0;
    end else begin
      state <= state_nxt;
      // Round 63 leaves RUN, so the counter returns to 0 instead of wrapping on.
      if (load)      t <= '0;
      else if (xfer) t <= last ? '0 : t + round_t'(1);
    end
  end

  sha256_w_window u_w_window (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (load),
    .shift   (xfer),
    .block   (bus.block),
    .w0      (w0)
  );

  assign bus.k_addr   = in_run ? t : '0;
  assign bus.kw_round = in_run ? t : '0;
  assign bus.kw_valid = in_run;
  assign bus.kw_data  = bus.k_data + w0;
  assign bus.busy     = in_run || in_done;
  assign bus.done     = in_done;

endmodule

// File: tb/tb_sha256_kw_sched.sv
// Self-checking bench for sha256_kw_sched against a plain-arithmetic
// SHA-256 message schedule model (W_0..W_63 computed as a flat array).
module tb_sha256_kw_sched;

  localparam logic [31:0] K_TAB [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [511:0] ABC  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] ONES = {512{1'b1}};

  logic clk;
  logic reset_n;

  sha256_kw_sched_if bus ();

  sha256_kw_sched dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  assign bus.k_data = K_TAB[bus.k_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [31:0] exp_kw [64];
  logic [31:0] got_d  [64];
  logic [5:0]  got_r  [64];
  int n_xfer;
  int done_cyc;
  int stable_err;
  int first_bad;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic void build_model(input logic [511:0] blk);
    logic [31:0] w [64];
    for (int i = 0; i < 64; i++) begin
      if (i < 16)
        w[i] = blk[511 - 32*i -: 32];
      else
        w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7]
             + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
      exp_kw[i] = K_TAB[i] + w[i];
    end
  endfunction

  // Number of collected words that differ from the model (data or round index).
  function automatic int seq_errors();
    int n = 0;
    first_bad = -1;
    for (int i = 0; i < 64; i++) begin
      if (i >= n_xfer || got_d[i] !== exp_kw[i] || got_r[i] !== 6'(i)) begin
        if (first_bad < 0) first_bad = i;
        n++;
      end
    end
    return n;
  endfunction

  function automatic logic [511:0] rand_block();
    logic [511:0] b;
    for (int i = 0; i < 16; i++) b[511 - 32*i -: 32] = $urandom();
    return b;
  endfunction

  // ready_mode: 0 = always high, 1 = low on odd cycles / high on even, 2 = random.
  // A second start with alt_blk is pulsed at cycle alt_cyc (ignored if < 1).
  task automatic run_collect(input logic [511:0] blk, input int ready_mode,
                             input int alt_cyc, input logic [511:0] alt_blk);
    logic        have_snap;
    logic [31:0] snap_d;
    logic [5:0]  snap_r;
    logic [5:0]  snap_a;
    n_xfer = 0; done_cyc = -1; stable_err = 0; have_snap = 0;
    snap_d = '0; snap_r = '0; snap_a = '0;
    for (int i = 0; i < 64; i++) begin got_d[i] = 'x; got_r[i] = 'x; end
    @(negedge clk);
    bus.start = 1'b1; bus.block = blk; bus.kw_ready = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc < 1000 && done_cyc < 0; cyc++) begin
      @(negedge clk);
      bus.start = (cyc == alt_cyc);
      if (cyc == alt_cyc) bus.block = alt_blk;
      case (ready_mode)
        0:       bus.kw_ready = 1'b1;
        1:       bus.kw_ready = (cyc % 2 == 0);
        default: bus.kw_ready = 1'($urandom_range(0, 1));
      endcase
      #1;
      if (have_snap && (bus.kw_data !== snap_d || bus.kw_round !== snap_r || bus.k_addr !== snap_a))
        stable_err++;
      have_snap = 0;
      if (bus.done) done_cyc = cyc;
      else if (bus.kw_valid) begin
        if (bus.kw_ready) begin
          if (n_xfer < 64) begin got_d[n_xfer] = bus.kw_data; got_r[n_xfer] = bus.kw_round; end
          n_xfer++;
        end else begin
          snap_d = bus.kw_data; snap_r = bus.kw_round; snap_a = bus.k_addr; have_snap = 1;
        end
      end
    end
    bus.start = 1'b0;
    bus.kw_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; bus.start = 1'b0; bus.block = '0; bus.kw_ready = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.kw_valid !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0 ||
        bus.k_addr !== 6'd0 || bus.kw_round !== 6'd0)
      $display("FAIL reset_outputs: valid=%b busy=%b done=%b k_addr=%0d round=%0d, required all 0",
               bus.kw_valid, bus.busy, bus.done, bus.k_addr, bus.kw_round);
    else passes++;
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (bus.busy !== 1'b0 || bus.kw_valid !== 1'b0 || ^bus.kw_data === 1'bx)
      $display("FAIL idle_after_reset: busy=%b valid=%b data=%h, required busy=0 valid=0 data driven",
               bus.busy, bus.kw_valid, bus.kw_data);
    else passes++;
  endtask

  task automatic test_abc();
    int e;
    build_model(ABC);
    run_collect(ABC, 0, -1, '0);
    checks++;
    if (got_d[0] !== 32'ha3ec9318) $display("FAIL abc_round0: got %h, required a3ec9318", got_d[0]);
    else passes++;
    checks++;
    if (got_d[15] !== 32'hc19bf18c) $display("FAIL abc_round15: got %h, required c19bf18c", got_d[15]);
    else passes++;
    checks++;
    if (got_d[16] !== 32'h45fdcd41) $display("FAIL abc_round16: got %h, required 45fdcd41", got_d[16]);
    else passes++;
    e = seq_errors();
    checks++;
    if (e !== 0) $display("FAIL abc_sequence: %0d bad words, first at %0d, required 0", e, first_bad);
    else passes++;
    checks++;
    if (n_xfer !== 64) $display("FAIL abc_xfer_count: got %0d, required 64", n_xfer);
    else passes++;
    checks++;
    if (done_cyc !== 65) $display("FAIL abc_done_cycle: got %0d, required 65", done_cyc);
    else passes++;
  endtask

  task automatic test_ready_toggle();
    int e;
    build_model(ABC);
    run_collect(ABC, 1, -1, '0);
    e = seq_errors();
    checks++;
    if (e !== 0) $display("FAIL toggle_sequence: %0d bad words, first at %0d, required 0", e, first_bad);
    else passes++;
    checks++;
    if (done_cyc !== 129) $display("FAIL toggle_done_cycle: got %0d, required 129", done_cyc);
    else passes++;
    checks++;
    if (stable_err !== 0) $display("FAIL toggle_stall_stable: got %0d changed stalls, required 0", stable_err);
    else passes++;
  endtask

  task automatic test_start_ignored();
    int e;
    build_model(ABC);
    run_collect(ABC, 0, 11, rand_block());
    e = seq_errors();
    checks++;
    if (e !== 0) $display("FAIL start_busy_sequence: %0d bad words, first at %0d, required 0", e, first_bad);
    else passes++;
    checks++;
    if (done_cyc !== 65) $display("FAIL start_busy_done: got %0d, required 65", done_cyc);
    else passes++;
  endtask

  task automatic test_reset_mid_run();
    bit hit = 0;
    bit done_seen = 0;
    int e;
    build_model(ABC);
    @(negedge clk);
    bus.start = 1'b1; bus.block = ABC; bus.kw_ready = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    for (int c = 0; c < 100; c++) begin
      if (bus.kw_valid && bus.kw_round == 6'd30) begin hit = 1; break; end
      @(negedge clk);
    end
    checks++;
    if (!hit) $display("FAIL midrun_reach_30: round 30 not seen, required seen");
    else passes++;
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.kw_valid !== 1'b0 || bus.busy !== 1'b0 || bus.kw_round !== 6'd0 || bus.k_addr !== 6'd0)
      $display("FAIL midrun_reset_immediate: valid=%b busy=%b round=%0d k_addr=%0d, required all 0",
               bus.kw_valid, bus.busy, bus.kw_round, bus.k_addr);
    else passes++;
    repeat (3) begin @(negedge clk); if (bus.done) done_seen = 1; end
    reset_n = 1'b1;
    repeat (4) begin @(negedge clk); if (bus.done || bus.busy) done_seen = 1; end
    checks++;
    if (done_seen) $display("FAIL midrun_no_done: done/busy seen after abort, required none");
    else passes++;
    run_collect(ABC, 0, -1, '0);
    e = seq_errors();
    checks++;
    if (e !== 0 || done_cyc !== 65)
      $display("FAIL midrun_restart: %0d bad words (first %0d), done at %0d, required 0 and 65",
               e, first_bad, done_cyc);
    else passes++;
  endtask

  task automatic test_all_ones();
    int e;
    build_model(ONES);
    run_collect(ONES, 0, -1, '0);
    checks++;
    if (got_d[0] !== 32'h428a2f97) $display("FAIL ones_round0_carry: got %h, required 428a2f97", got_d[0]);
    else passes++;
    e = seq_errors();
    checks++;
    if (e !== 0) $display("FAIL ones_sequence: %0d bad words, first at %0d, required 0", e, first_bad);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int done_at [2];
    int xfers [2];
    int nd = 0;
    int bad = 0;
    logic idle_busy = 1'bx;
    logic idle_valid = 1'bx;
    done_at[0] = -1; done_at[1] = -1; xfers[0] = 0; xfers[1] = 0;
    build_model(ABC);
    @(negedge clk);
    bus.start = 1'b1; bus.block = ABC; bus.kw_ready = 1'b1;
    @(posedge clk);
    for (int cyc = 1; cyc < 400 && nd < 2; cyc++) begin
      @(negedge clk);
      #1;
      if (cyc == 66) begin idle_busy = bus.busy; idle_valid = bus.kw_valid; end
      if (bus.done) begin done_at[nd] = cyc; nd++; end
      else if (bus.kw_valid) begin
        if (bus.kw_data !== exp_kw[bus.kw_round]) bad++;
        xfers[nd]++;
      end
    end
    bus.start = 1'b0;
    checks++;
    if (done_at[0] !== 65 || done_at[1] !== 131)
      $display("FAIL b2b_done_cycles: got %0d,%0d, required 65,131", done_at[0], done_at[1]);
    else passes++;
    checks++;
    if (xfers[0] !== 64 || xfers[1] !== 64)
      $display("FAIL b2b_xfer_counts: got %0d,%0d, required 64,64", xfers[0], xfers[1]);
    else passes++;
    checks++;
    if (idle_busy !== 1'b0 || idle_valid !== 1'b0)
      $display("FAIL b2b_idle_gap: busy=%b valid=%b at cycle 66, required 0,0", idle_busy, idle_valid);
    else passes++;
    checks++;
    if (bad !== 0) $display("FAIL b2b_data: %0d bad words, required 0", bad);
    else passes++;
    @(negedge clk);
  endtask

  task automatic test_random();
    int e;
    logic [511:0] b;
    for (int r = 0; r < 6; r++) begin
      b = rand_block();
      build_model(b);
      run_collect(b, 2, -1, '0);
      e = seq_errors();
      checks++;
      if (e !== 0 || done_cyc < 65 || stable_err !== 0)
        $display("FAIL random_run%0d: %0d bad words (first %0d), done %0d, stalls changed %0d, required 0/>=65/0",
                 r, e, first_bad, done_cyc, stable_err);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_abc();
    test_ready_toggle();
    test_start_ignored();
    test_reset_mid_run();
    test_all_ones();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/sha256_kw_sched.md
SHA256_KW_SCHED -- requirements
Module: sha256_kw_sched

Interface
REQ-001 Parameters: none; all widths are fixed by SHA-256.
REQ-002 clk  input  1  single clock for the block; all state changes on its rising edge.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to load block and begin a 64-round schedule; sampled only in IDLE.
REQ-005 block  input  512  message block; W0 = block[511:480], W15 = block[31:0].
REQ-006 k_addr  output  6  round-constant table address; the table returns K for this address combinationally.
REQ-007 k_data  input  32  round constant K[k_addr], valid in the same cycle as k_addr.
REQ-008 kw_valid  output  1  kw_data/kw_round hold a valid round word.
REQ-009 kw_ready  input  1  consumer accepts the round word; transfer when kw_valid && kw_ready.
REQ-010 kw_data  output  32  (K_t + W_t) mod 2^32 for round t.
REQ-011 kw_round  output  6  round index t of kw_data.
REQ-012 busy  output  1  high in RUN and DONE.
REQ-013 done  output  1  one-cycle pulse after round 63 is transferred.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE.
- IDLE->RUN on start.
- RUN->DONE on a transfer with t=63.
- DONE->IDLE unconditionally after one cycle.
REQ-015 On start in IDLE, the block SHALL capture block into a 16-word window w[0..15] (w[0]=W0) and set t=0; the first kw_valid SHALL be high the following cycle.
REQ-016 In RUN: k_addr=t, kw_round=t, kw_valid=1, kw_data = k_data + w[0]; the addition SHALL be 32-bit wrap-around, carry discarded.
REQ-017 On each transfer in RUN, the window SHALL shift down one word and w[15] SHALL be loaded with the new word: new = sig1(w[14]) + w[9] + sig0(w[1]) + w[0], mod 2^32.
- sig0(x) = ROTR7 ^ ROTR18 ^ SHR3.
- sig1(x) = ROTR17 ^ ROTR19 ^ SHR10.
- t SHALL increment by 1.
REQ-018 This expansion rule SHALL apply for every t; no separate path for t<16.
REQ-019 With kw_ready low, kw_data, kw_round, k_addr and the window SHALL remain unchanged (no bubble, no loss).
REQ-020 The 6-bit round counter SHALL be saturated by the FSM: after the t=63 transfer it SHALL NOT wrap into a 65th round.
REQ-021 start SHALL be ignored while busy=1; block is sampled only on the accepted start.
REQ-022 In IDLE and DONE: kw_valid=0, k_addr=0, kw_round=0; kw_data is don't-care but SHALL be driven, not X.
REQ-023 done SHALL be high exactly in the DONE state; busy SHALL be high in RUN and DONE.
REQ-024 Throughput SHALL be one round per cycle with kw_ready held high: start at cycle 0 gives round 0 at cycle 1, round 63 at cycle 64, done at cycle 65.

Reset
REQ-025 reset_n low SHALL immediately force IDLE, t=0, window=0, kw_valid=0, busy=0, done=0, k_addr=0, kw_round=0.
REQ-026 Reset asserted mid-RUN SHALL abort the schedule with no done pulse; a new start is required after release.

Structure
REQ-027 A shared sha256 package SHALL hold the FSM state encoding, the round count (64) and the sig0/sig1 functions.
REQ-028 The block SHALL contain one natural sub-module, sha256_w_window: the 16x32 shift window plus the expansion adder, with load, shift, w0 out.
REQ-029 The existing K constant table SHALL be instantiated outside this block and connected via k_addr/k_data.

Verification
REQ-030 Block "abc" (W0=0x61626380, W15=0x00000018, other words 0), kw_ready=1, start:
- round 0: kw_data=0xa3ec9318.
- round 15: kw_data=0xc19bf18c.
- round 16: kw_data=0x45fdcd41.
- done pulses at cycle 65.
REQ-031 Same block with kw_ready toggling 1/0 every cycle: identical 64-word kw_data sequence; done at cycle 129; outputs stable during every ready-low cycle.
REQ-032 start pulsed at round 10 with a different block: ignored; the sequence matches REQ-030.
REQ-033 reset_n asserted at round 30: kw_valid=0 and busy=0 immediately, no done pulse; a fresh start restarts at round 0 with correct values.
REQ-034 Block of all 0xffffffff: round 0 kw_data=0x428a2f97, confirming the carry-out is discarded.
REQ-035 start held high continuously: back-to-back schedules separated by exactly one DONE cycle and one IDLE cycle; each run delivers exactly 64 transfers.
